// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-stage register scoreboard.
package pipe_pkg;

    localparam int REG_COUNT    = 32;
    localparam int MAX_INFLIGHT = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; all-zero output when disabled.
module onehot_dec #(
    parameter int IDX_W = 5,
    parameter int OUT_W = 32
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes, gates issue on RAW/WAW hazards,
// in-flight capacity and fences.
module reg_scoreboard
    import pipe_pkg::sched_state_t;
    import pipe_pkg::RUN;
    import pipe_pkg::DRAIN;
#(
    parameter int REG_COUNT    = pipe_pkg::REG_COUNT,
    parameter int REG_BITS     = $clog2(REG_COUNT),
    parameter int MAX_INFLIGHT = pipe_pkg::MAX_INFLIGHT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 dec_valid,
    input  logic [REG_BITS-1:0]  rs1,
    input  logic [REG_BITS-1:0]  rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [REG_BITS-1:0]  rd,
    input  logic                 rd_wr,
    input  logic                 fence,
    input  logic                 ex_ready,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [REG_BITS-1:0]  wb_reg,
    output logic                 issue,
    output logic                 stall,
    output logic [REG_COUNT-1:0] busy_vec,
    output logic [3:0]           inflight_cnt,
    output logic                 draining
);

    sched_state_t         state;
    logic                 hazard;
    logic                 writer;
    logic                 full;
    logic                 cnt_zero;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] wb_mask;
    logic [REG_COUNT-1:0] clr_mask;
    logic                 inc;
    logic                 dec;

    // Hazards look only at the registered busy bits; a writeback landing this
    // cycle does not release a dependent instruction until the next cycle.
    assign hazard = (rs1_used && (rs1 != '0) && busy_vec[rs1]) ||
                    (rs2_used && (rs2 != '0) && busy_vec[rs2]) ||
                    (rd_wr    && (rd  != '0) && busy_vec[rd]);

    assign writer   = rd_wr && (rd != '0);
    assign full     = (inflight_cnt == 4'(MAX_INFLIGHT));
    assign cnt_zero = (inflight_cnt == 4'd0);

    assign issue = dec_valid && ex_ready && !flush && !hazard &&
                   !(writer && full) && !(fence && !cnt_zero) &&
                   (state == RUN);
    assign stall    = dec_valid && !issue && !flush;
    assign draining = (state == DRAIN);

    onehot_dec #(.IDX_W(REG_BITS), .OUT_W(REG_COUNT)) u_set_dec (
        .en     (issue && writer),
        .idx    (rd),
        .onehot (set_mask)
    );

    onehot_dec #(.IDX_W(REG_BITS), .OUT_W(REG_COUNT)) u_clr_dec (
        .en     (wb_en && (wb_reg != '0)),
        .idx    (wb_reg),
        .onehot (wb_mask)
    );

    // Writebacks to registers that are not pending are dropped entirely.
    assign clr_mask = wb_mask & busy_vec;
    assign inc      = |set_mask;
    assign dec      = (|clr_mask) && !cnt_zero;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_vec     <= '0;
            inflight_cnt <= 4'd0;
            state        <= RUN;
        end else begin
            // Set is applied after clear so a same-register collision keeps the bit.
            busy_vec     <= ((busy_vec & ~clr_mask) | set_mask) & ~REG_COUNT'(1);
            inflight_cnt <= inflight_cnt + 4'(inc) - 4'(dec);
            case (state)
                RUN: begin
                    if (dec_valid && fence && !flush && !cnt_zero) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush || cnt_zero) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter REG_COUNT, default 32, number of architectural registers.
REQ-002 Parameter REG_BITS, default $clog2(REG_COUNT), register index width.
REQ-003 Parameter MAX_INFLIGHT, default 4, maximum outstanding register writes; legal range 1..15.
REQ-004 Ports (one per line):
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- rs1, rs2  in  REG_BITS each  source indices.
- rs1_used, rs2_used  in  1 each  source is actually read.
- rd  in  REG_BITS  destination index.
- rd_wr  in  1  instruction writes rd.
- fence  in  1  instruction requires an empty pipeline before issue.
- ex_ready  in  1  execute stage can accept.
- flush  in  1  kill the decode instruction this cycle.
- wb_en  in  1  writeback occurring.
- wb_reg  in  REG_BITS  writeback index.
- issue  out  1  instruction moves decode->execute this cycle.
- stall  out  1  dec_valid & ~issue & ~flush.
- busy_vec  out  REG_COUNT  registered pending-write bits.
- inflight_cnt  out  4  registered outstanding-write count.
- draining  out  1  FSM in DRAIN.

Function
REQ-005 Hazard = (rs1_used & rs1!=0 & busy_vec[rs1]) | (rs2_used & rs2!=0 & busy_vec[rs2]) | (rd_wr & rd!=0 & busy_vec[rd]); evaluated from registered busy_vec only, with no same-cycle writeback bypass.
REQ-006 Full = inflight_cnt == MAX_INFLIGHT; a writer (rd_wr & rd!=0) is blocked when Full.
REQ-007 issue = dec_valid & ex_ready & ~flush & ~hazard & ~(writer & Full) & ~(fence & inflight_cnt!=0) & state==RUN; combinational, zero latency.
REQ-008 On an issue of a writer, busy_vec[rd] is set at the next edge and inflight_cnt increments.
REQ-009 wb_en with wb_reg!=0 and busy_vec[wb_reg]==1 clears that bit and decrements inflight_cnt at the next edge; wb_en to a non-busy register or to x0 is ignored.
REQ-010 Same-cycle issue-set and writeback-clear of different registers: both apply; net inflight_cnt change is 0.
REQ-011 Same-cycle issue-set and writeback-clear of the same register is unreachable (the WAW hazard blocks it); if it occurs, set wins and the count is unchanged.
REQ-012 busy_vec[0] is constant 0; issue with rd==0 or rd_wr==0 changes no state.
REQ-013 FSM states: RUN, DRAIN.
- RUN->DRAIN when dec_valid & fence & ~flush & inflight_cnt!=0.
- DRAIN->RUN when inflight_cnt==0; the fence instruction issues in the first RUN cycle after that, subject to ex_ready.
- flush in DRAIN returns to RUN at the next edge.
REQ-014 flush forces issue=0 and stall=0 in that cycle; busy_vec and inflight_cnt are not altered by flush, and pending writebacks are still honoured.
REQ-015 inflight_cnt never exceeds MAX_INFLIGHT and never underflows.

Reset
REQ-016 rstn low asynchronously forces busy_vec=0, inflight_cnt=0 and state=RUN; issue, stall and draining then read 0 if dec_valid=0.
REQ-017 Reset mid-DRAIN or with writes outstanding discards all tracking; later wb_en to those registers is ignored per REQ-009.

Structure
REQ-018 Shared package pipe_pkg holds REG_COUNT, the sched_state_t enum {RUN, DRAIN} and MAX_INFLIGHT default.
REQ-019 Sub-module onehot_dec (REG_BITS -> REG_COUNT one-hot, with enable) generates the set and clear masks, instantiated twice.

Verification
REQ-020 Issue add x5 (rd_wr=1), next cycle sub reading rs1=x5 -> stall=1 until cycle after wb_en,wb_reg=5; then issue=1.
REQ-021 Issue four writers to x1..x4 without writeback -> inflight_cnt=4, fifth writer x6 stalls; wb_reg=2 -> x6 issues next cycle, count returns to 4.
REQ-022 fence with inflight_cnt=2 -> draining=1; two writebacks -> RUN, fence issues, draining=0.
REQ-023 Same-cycle issue writer x7 and wb_en x3 (busy) -> busy_vec[7]=1, busy_vec[3]=0, count unchanged.
REQ-024 Writers to x0 and wb_en to non-busy x9 -> busy_vec and inflight_cnt unchanged.
REQ-025 Assert rstn=0 mid-DRAIN with count=3 -> immediately count=0, busy_vec=0, state RUN.
